// File: rtl/fifo_stream_out.sv
// fifo_stream_out: drains a 1-cycle-latency FIFO read port into a valid/ready stream and counts delivered beats.
// Latency: fifo_rd in cycle N, data captured end of N+1, m_valid in N+2; sustains 1 beat/clk with m_ready high.
// Backpressure: 2-entry head/skid buffer; fifo_rd is withheld once buffered + in-flight bytes reach 2. Optional FIFO_STREAM_PARITY_EN adds m_parity.
module fifo_stream_out #(
   parameter int DW    = 8,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             fifo_empty,
   output logic             fifo_rd,
   input  logic [DW-1:0]    fifo_dout,
   output logic             m_valid,
   input  logic             m_ready,
   output logic [DW-1:0]    m_data,
`ifdef FIFO_STREAM_PARITY_EN
   output logic             m_parity,
`endif
   output logic [CNT_W-1:0] beat_cnt
);

   // Buffer storage: head drives the output, skid catches the byte that lands while head is held.
   logic [DW-1:0] head_dat;
   logic [DW-1:0] skid_dat;
   logic [DW-1:0] head_dat_nxt;
   logic [DW-1:0] skid_dat_nxt;
   logic [1:0]    occ;
   logic [1:0]    occ_nxt;
   logic [1:0]    occ_after_pop;
   logic          inflight;
   logic          pop;
   // Bytes owned by this stage after this cycle's pop (buffered + in flight); 0..2.
   logic [2:0]    level;

`ifdef FIFO_STREAM_PARITY_EN
   logic          head_par;
   logic          skid_par;
   logic          head_par_nxt;
   logic          skid_par_nxt;
   logic          cap_par;
`endif

   assign m_valid = (occ != 2'd0);
   assign m_data  = head_dat;
   assign pop     = m_valid && m_ready;
   assign level   = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
   // Read credit check uses the post-pop level so a draining sink keeps reads flowing every cycle.
   assign fifo_rd = !rst && !fifo_empty && (level < 3'd2);

`ifdef FIFO_STREAM_PARITY_EN
   assign cap_par  = ^fifo_dout;
   assign m_parity = head_par;
`endif

   // Next buffer contents: shift skid into head on pop, then place the returning byte in the first free slot.
   always_comb begin
      occ_after_pop = occ - {1'b0, pop};
      head_dat_nxt  = head_dat;
      skid_dat_nxt  = skid_dat;
`ifdef FIFO_STREAM_PARITY_EN
      head_par_nxt  = head_par;
      skid_par_nxt  = skid_par;
`endif
      if (pop && (occ == 2'd2)) begin
         head_dat_nxt = skid_dat;
`ifdef FIFO_STREAM_PARITY_EN
         head_par_nxt = skid_par;
`endif
      end
      // The credit rule guarantees at most one byte is resident here whenever inflight is set.
      if (inflight) begin
         if (occ_after_pop == 2'd0) begin
            head_dat_nxt = fifo_dout;
`ifdef FIFO_STREAM_PARITY_EN
            head_par_nxt = cap_par;
`endif
         end else begin
            skid_dat_nxt = fifo_dout;
`ifdef FIFO_STREAM_PARITY_EN
            skid_par_nxt = cap_par;
`endif
         end
      end
      occ_nxt = level[1:0];
   end

   // State registers: buffer, occupancy, in-flight marker and delivered-beat counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head_dat <= '0;
         skid_dat <= '0;
         occ      <= 2'd0;
         inflight <= 1'b0;
         beat_cnt <= '0;
`ifdef FIFO_STREAM_PARITY_EN
         head_par <= 1'b0;
         skid_par <= 1'b0;
`endif
      end else begin
         head_dat <= head_dat_nxt;
         skid_dat <= skid_dat_nxt;
         occ      <= occ_nxt;
         inflight <= fifo_rd;
         if (pop) begin
            beat_cnt <= beat_cnt + CNT_W'(1);
         end
`ifdef FIFO_STREAM_PARITY_EN
         head_par <= head_par_nxt;
         skid_par <= skid_par_nxt;
`endif
      end
   end

endmodule

// File: doc/fifo_stream_out.md
# fifo_stream_out

Drain stage that sits directly downstream of the 16-deep byte FIFO. It converts the FIFO's rd/dout/empty read port, where data returns one cycle after rd, into a valid/ready streaming master. A 2-entry output buffer with read credits sustains one beat per clock when the sink is ready and never loses a byte under backpressure. It also keeps a free-running count of delivered beats.

## Interface
Parameters:
- DW, 8, data width; must match the FIFO data width
- CNT_W, 16, width of the delivered-beat counter

Ports:
- clk  input  1  single clock; all state updates on its rising edge
- rst  input  1  reset, asynchronous, active-high
- fifo_empty  input  1  FIFO empty flag, combinational from FIFO count
- fifo_rd  output  1  FIFO read strobe, combinational
- fifo_dout  input  DW  FIFO read data; valid in the cycle after fifo_rd was high
- m_valid  output  1  output beat valid
- m_ready  input  1  sink ready
- m_data  output  DW  output beat data
- beat_cnt  output  CNT_W  number of beats accepted by the sink; wraps modulo 2^CNT_W

## Operation
- **Buffer:** two entries, head and skid. m_data/m_valid come from head only.
- **occ:** occupancy 0..2.
- **inflight:** 1-bit register, set to the registered value of fifo_rd. It marks that fifo_dout must be captured in the current cycle.
- **pop:** m_valid && m_ready.
- **Read issue rule:** fifo_rd = !rst && !fifo_empty && (occ + inflight − pop) < 2. This is combinational from m_ready, so the FIFO is never over-read and the buffer never overflows.
- **Capture when inflight=1:**
  - If the buffer is empty, or holds only head and pop=1, the data goes to head.
  - Otherwise it goes to skid.
- **Pop handling:** when pop=1, skid moves to head if occupied. The same-cycle capture then lands in the vacated slot.
- **Ordering:** strictly FIFO; bytes leave in the order read.
- **Hold rule:** once m_valid=1, m_data and m_valid hold stable until pop.
- **beat_cnt:** increments by 1 on every pop and wraps from 2^CNT_W−1 to 0.
- **Simultaneous events:** capture, pop and a new fifo_rd may all occur in one cycle. occ' = occ + inflight − pop.
- **Empty FIFO:** fifo_rd stays 0. The block never relies on the FIFO ignoring an illegal read.

## Timing
- **Reset values:** m_valid=0, m_data=0, beat_cnt=0, occ=0, inflight=0, fifo_rd=0.
- **Reset mid-operation:** an in-flight byte is discarded and buffered bytes are dropped. The FIFO shares rst, so no resynchronisation is needed.
- **Latency:**
  - fifo_rd high in cycle N.
  - fifo_dout valid in cycle N+1 and captured at the end of N+1.
  - m_valid=1 in cycle N+2.
  - Minimum FIFO-nonempty to m_valid is therefore 2 cycles.
- **Throughput:** 1 beat/cycle with m_ready held high and the FIFO non-empty. The steady state is occ=1, inflight=1, fifo_rd=1 every cycle.
- **Backpressure:** with m_ready=0, at most 2 reads complete after m_valid rises, then fifo_rd=0. When m_ready returns, the first pop happens in that cycle and fifo_rd reasserts in the same cycle.

## Configuration
- **Macro:** FIFO_STREAM_PARITY_EN.
- **Defined:**
  - Adds the output port m_parity (1 bit) = ^m_data, i.e. even parity over the beat.
  - It is stored with each buffer entry and computed at capture, not from m_data combinationally.
  - Reset value 0.
  - It follows the same hold rule as m_data.
- **Undefined:** the port and its storage are absent. All other behaviour is identical.

## Test plan
- **Reset:** assert rst asynchronously mid-cycle -> m_valid=0, fifo_rd=0, beat_cnt=0 immediately, without waiting for a clock edge.
- **Single byte:** FIFO holds 8'hA5, m_ready=1 -> fifo_rd for 1 cycle, m_valid=1 with m_data=8'hA5 two cycles later, beat_cnt=1, then m_valid=0.
- **Streaming:** FIFO holds 16 bytes 0x00..0x0F, m_ready=1 -> 16 consecutive beats in order, no gaps after the first, beat_cnt=16, fifo_rd never high while fifo_empty=1.
- **Backpressure:** FIFO holds 4 bytes, m_ready=0 for 10 cycles -> exactly 2 fifo_rd pulses, m_data=first byte held stable. After m_ready=1, the remaining bytes arrive in order with no loss or duplication.
- **Random ready:** random m_ready toggling over 200 bytes -> scoreboard exact order match, occ never >2, beat_cnt=200.
- **Counter wrap / parity:** with CNT_W=4, 17 beats -> beat_cnt=1. With FIFO_STREAM_PARITY_EN, m_data=8'h07 gives m_parity=1 and 8'h03 gives m_parity=0.
